// File: rtl/memory_write_mapping_pkg.sv
// memory_write_mapping_pkg: region codes, FSM encoding and address map shared by the load- and store-side mappers
package memory_write_mapping_pkg;
   typedef enum logic [1:0] {RAM = 2'b00, KEYBOARD = 2'b01, ROM = 2'b10, OUTDEV = 2'b11} region_t;
   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, FINISH} state_t;
   typedef enum logic [1:0] {K_RAM, K_LED, K_KACK, K_FAULT} kind_t;
   localparam logic [15:0] KBD_ADDR     = 16'hFE00;
   localparam logic [15:0] LED_ADDR     = 16'hFE02;
   localparam logic [15:0] KBD_ACK_ADDR = 16'hFE04;
   localparam logic [7:0]  ROM_PAGE     = 8'hFF;
endpackage

// File: rtl/memory_write_mapping_mem_region_decode.sv
// mem_region_decode: combinational virtual address to region code, shared by load and store paths
module mem_region_decode
   import memory_write_mapping_pkg::*;
#(
   parameter logic [15:0] OUT_ADDR_A = LED_ADDR,
   parameter logic [15:0] OUT_ADDR_B = KBD_ACK_ADDR
) (
   input  logic [15:0] addr,
   output region_t     region
);
   // Unclaimed high space (including the FFxx ROM page) decodes as read-only
   always_comb
      region = !addr[15] ? RAM :
               addr == KBD_ADDR ? KEYBOARD :
               (addr == OUT_ADDR_A || addr == OUT_ADDR_B) ? OUTDEV : ROM;
endmodule

// File: rtl/memory_write_mapping.sv
// memory_write_mapping: decodes one CPU store and performs a timed SRAM write, LED/kbd-ack update or fault
module memory_write_mapping
   import memory_write_mapping_pkg::*;
#(
   parameter int          WE_PULSE     = 2,
   parameter logic [15:0] LED_ADDR     = 16'hFE02,
   parameter logic [15:0] KBD_ACK_ADDR = 16'hFE04
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wrReq,
   input  logic [15:0] virtualAddr,
   input  logic [15:0] wrData,
   output logic        busy,
   output logic        done,
   output logic        wrFault,
   output logic [15:0] ramAddr,
   output logic [15:0] ramDataOut,
   output logic        ramDataOe,
   output logic        ramWe_n,
   output logic [15:0] ledOut,
   output logic        kbdAck
);
   region_t     region;
   kind_t       kind_acc, kind_q, kind_d;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] ram_addr_q, ram_addr_d, ram_data_q, ram_data_d, led_q, led_d;
   logic        busy_q, busy_d, done_q, done_d, fault_q, fault_d;
   logic        oe_q, oe_d, we_n_q, we_n_d, kack_q, kack_d;
   mem_region_decode #(.OUT_ADDR_A(LED_ADDR), .OUT_ADDR_B(KBD_ACK_ADDR)) u_decode (
      .addr  (virtualAddr),
      .region(region)
   );
   always_comb
      kind_acc = region == RAM ? K_RAM :
                 region == OUTDEV ? (virtualAddr == LED_ADDR ? K_LED : K_KACK) : K_FAULT;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         kind_q     <= K_RAM;
         cnt_q      <= '0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         led_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         fault_q    <= 1'b0;
         oe_q       <= 1'b0;
         we_n_q     <= 1'b1;
         kack_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         cnt_q      <= cnt_d;
         ram_addr_q <= ram_addr_d;
         ram_data_q <= ram_data_d;
         led_q      <= led_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         fault_q    <= fault_d;
         oe_q       <= oe_d;
         we_n_q     <= we_n_d;
         kack_q     <= kack_d;
      end
   end
   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      cnt_d      = cnt_q;
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;
      led_d      = led_q;
      case (state_q)
         IDLE: if (wrReq) begin
            kind_d     = kind_acc;
            state_d    = kind_acc == K_RAM ? SETUP : FINISH;
            ram_addr_d = kind_acc == K_RAM ? {1'b0, virtualAddr[15:1]} : ram_addr_q;
            ram_data_d = kind_acc == K_RAM ? wrData : ram_data_q;
            led_d      = kind_acc == K_LED ? wrData : led_q;
         end
         SETUP: begin
            state_d = PULSE;
            cnt_d   = 4'(WE_PULSE - 1);
         end
         PULSE: begin
            state_d = cnt_q == 4'd0 ? HOLD : PULSE;
            cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
         end
         HOLD:    state_d = FINISH;
         default: state_d = IDLE;
      endcase
   end
   // Outputs are decoded from the next state so every port comes straight off a flop
   always_comb begin
      oe_d    = state_d == SETUP || state_d == PULSE || state_d == HOLD;
      busy_d  = oe_d || (state_d == FINISH && kind_d != K_RAM);
      done_d  = state_d == FINISH;
      fault_d = done_d && kind_d == K_FAULT;
      kack_d  = done_d && kind_d == K_KACK;
      we_n_d  = state_d != PULSE;
   end
   assign busy       = busy_q;
   assign done       = done_q;
   assign wrFault    = fault_q;
   assign ramAddr    = ram_addr_q;
   assign ramDataOut = ram_data_q;
   assign ramDataOe  = oe_q;
   assign ramWe_n    = we_n_q;
   assign ledOut     = led_q;
   assign kbdAck     = kack_q;
endmodule
